// File: rtl/mario_sprite_ctrl.sv
// Mario sprite controller: walk/jump animation FSM, per-frame position latch and a
// 3-stage pixel pipeline driving an external sprite ROM. Define MARIO_MIRROR_EN to
// draw left-facing sprites by mirroring the right-facing ROMs.
module mario_sprite_ctrl #(
  parameter int unsigned SPRITE_DIM  = 32,
  parameter logic [11:0] KEY_RGB     = 12'hF0F,
  parameter int unsigned WALK_FRAMES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [9:0]  mario_x,
  input  logic [9:0]  mario_y,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        airborne,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [9:0]  rom_addr,
  output logic [2:0]  rom_sel,
  input  logic [11:0] rom_data,
  output logic        pix_valid,
  output logic [11:0] pix_rgb,
  output logic        facing,
  output logic [1:0]  anim_state
);

  localparam int unsigned DIM_LOG2  = $clog2(SPRITE_DIM);
  localparam logic [9:0]  DIM_MAX   = 10'(SPRITE_DIM - 1);
  localparam logic [7:0]  WALK_LAST = 8'(WALK_FRAMES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WALK_A = 2'd1;
  localparam logic [1:0] ST_WALK_B = 2'd2;
  localparam logic [1:0] ST_JUMP   = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] walk_cnt_q, walk_cnt_d;
  logic       facing_q, facing_d;
  logic [9:0] pos_x_q, pos_y_q;
  logic       armed_q;
  logic       hit_q, hit_dly_q;

  logic       one_dir;
  logic [9:0] dx, dy, col, addr_d;
  logic       hit;
  logic [1:0] kind;
  logic       sel_dir;
  logic [2:0] sel_d;
  logic       pix_on;

  // Animation FSM; only advances on frame ticks.
  always_comb begin
    state_d    = state_q;
    walk_cnt_d = walk_cnt_q;
    facing_d   = facing_q;
    one_dir    = move_left ^ move_right;
    if (frame_tick) begin
      if (airborne) begin
        state_d = ST_JUMP;
      end else if (one_dir) begin
        if (state_q == ST_WALK_A || state_q == ST_WALK_B) begin
          if (walk_cnt_q == WALK_LAST) begin
            walk_cnt_d = 8'd0;
            state_d    = (state_q == ST_WALK_A) ? ST_WALK_B : ST_WALK_A;
          end else begin
            walk_cnt_d = walk_cnt_q + 8'd1;
          end
        end else begin
          state_d    = ST_WALK_A;
          walk_cnt_d = 8'd0;
        end
      end else begin
        state_d    = ST_IDLE;
        walk_cnt_d = 8'd0;
      end
      if (move_right && !move_left) begin
        facing_d = 1'b0;
      end else if (move_left && !move_right) begin
        facing_d = 1'b1;
      end
    end
  end

  // Pixel issue stage; uses the latched position so mid-frame moves cannot tear.
  always_comb begin
    dx  = hcount - pos_x_q;
    dy  = vcount - pos_y_q;
    hit = (dx <= DIM_MAX) && (dy <= DIM_MAX);
`ifdef MARIO_MIRROR_EN
    col     = facing_q ? (DIM_MAX - dx) : dx;
    sel_dir = 1'b0;
`else
    col     = dx;
    sel_dir = facing_q;
`endif
    addr_d = (dy << DIM_LOG2) | (col & DIM_MAX);
    case (state_q)
      ST_WALK_A: kind = 2'd1;
      ST_JUMP:   kind = 2'd2;
      default:   kind = 2'd0;
    endcase
    sel_d  = {kind, sel_dir};
    pix_on = hit_dly_q && armed_q && (rom_data != KEY_RGB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      walk_cnt_q <= 8'd0;
      facing_q   <= 1'b0;
      pos_x_q    <= 10'd0;
      pos_y_q    <= 10'd0;
      armed_q    <= 1'b0;
      hit_q      <= 1'b0;
      hit_dly_q  <= 1'b0;
      rom_addr   <= 10'd0;
      rom_sel    <= 3'd0;
      pix_valid  <= 1'b0;
      pix_rgb    <= 12'h000;
    end else begin
      state_q    <= state_d;
      walk_cnt_q <= walk_cnt_d;
      facing_q   <= facing_d;
      if (frame_tick) begin
        pos_x_q <= mario_x;
        pos_y_q <= mario_y;
        armed_q <= 1'b1;
      end
      rom_addr  <= addr_d;
      rom_sel   <= sel_d;
      hit_q     <= hit;
      // hit_dly_q lines up with rom_data, which the ROM returns one cycle after the address.
      hit_dly_q <= hit_q;
      pix_valid <= pix_on;
      pix_rgb   <= pix_on ? rom_data : 12'h000;
    end
  end

  assign anim_state = state_q;
  assign facing     = facing_q;

endmodule

// File: tb/tb_mario_sprite_ctrl.sv
// Self-checking bench for mario_sprite_ctrl: table-driven FSM vectors, hand-written
// pipeline corner cases and a randomized run against a behavioural model.
module tb_mario_sprite_ctrl;

  localparam logic [11:0] KEY = 12'hF0F;
`ifdef MARIO_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  logic        clk, rst_n, frame_tick;
  logic [9:0]  mario_x, mario_y, hcount, vcount;
  logic        move_left, move_right, airborne;
  logic [9:0]  rom_addr;
  logic [2:0]  rom_sel;
  logic [11:0] rom_data;
  logic        pix_valid;
  logic [11:0] pix_rgb;
  logic        facing;
  logic [1:0]  anim_state;

  mario_sprite_ctrl #(
    .SPRITE_DIM (32),
    .KEY_RGB    (12'hF0F),
    .WALK_FRAMES(6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .mario_x   (mario_x),
    .mario_y   (mario_y),
    .move_left (move_left),
    .move_right(move_right),
    .airborne  (airborne),
    .hcount    (hcount),
    .vcount    (vcount),
    .rom_addr  (rom_addr),
    .rom_sel   (rom_sel),
    .rom_data  (rom_data),
    .pix_valid (pix_valid),
    .pix_rgb   (pix_rgb),
    .facing    (facing),
    .anim_state(anim_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synthetic sprite ROM: low address bits 3 give the key colour, 4 give green.
  function automatic logic [11:0] rom_fn(input logic [2:0] sel, input logic [9:0] addr);
    int v;
    if (addr[2:0] == 3'd3) return 12'hF0F;
    if (addr[2:0] == 3'd4) return 12'h0F0;
    v = int'(addr) * 5 + int'(sel) * 97 + 1;
    return v[11:0];
  endfunction

  initial rom_data = 12'h000;
  always @(posedge clk) rom_data <= rom_fn(rom_sel, rom_addr);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state.
  typedef struct {
    bit hit;
    int addr;
    int sel;
  } rec_t;

  int   m_state, m_cnt, m_px, m_py;
  bit   m_face, m_armed;
  rec_t r0, r1;
  bit   e_pv;
  int   e_rgb;

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_px = 0; m_py = 0; m_face = 0; m_armed = 0;
    r0 = '{hit: 0, addr: 0, sel: 0};
    r1 = '{hit: 0, addr: 0, sel: 0};
    e_pv = 0; e_rgb = 0;
  endtask

  task automatic model_edge();
    rec_t nr;
    int dx, dy, col, kind;
    logic [11:0] d;
    if (!rst_n) return;
    dx = (int'(hcount) - m_px) & 1023;
    dy = (int'(vcount) - m_py) & 1023;
    nr.hit = (dx < 32) && (dy < 32);
    col = (MIRROR && m_face) ? 31 - dx : dx;
    nr.addr = (dy * 32 + (col & 31)) & 1023;
    kind = (m_state == 3) ? 2 : (m_state == 1) ? 1 : 0;
    nr.sel = 2 * kind + (MIRROR ? 0 : int'(m_face));
    d = rom_fn(3'(r1.sel), 10'(r1.addr));
    e_pv = r1.hit && m_armed && (d != KEY);
    e_rgb = e_pv ? int'(d) : 0;
    r1 = r0;
    r0 = nr;
    if (frame_tick) begin
      if (airborne) m_state = 3;
      else if (move_left != move_right) begin
        if (m_state == 1 || m_state == 2) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == 6) begin
            m_cnt = 0;
            m_state = 3 - m_state;
          end
        end else begin
          m_state = 1;
          m_cnt = 0;
        end
      end else m_state = 0;
      if (move_right && !move_left) m_face = 0;
      if (move_left && !move_right) m_face = 1;
      m_px = int'(mario_x);
      m_py = int'(mario_y);
      m_armed = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_state", 32'(anim_state), 32'(m_state));
    check("model_facing", 32'(facing), 32'(m_face));
    check("model_sel", 32'(rom_sel), 32'(r0.sel));
    if (r0.hit) check("model_addr", 32'(rom_addr), 32'(r0.addr));
    check("model_pv", 32'(pix_valid), 32'(e_pv));
    check("model_rgb", 32'(pix_rgb), 32'(e_rgb));
  endtask

  // Mid-cycle asynchronous reset; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_pv", 32'(pix_valid), 32'd0);
    check("rst_rgb", 32'(pix_rgb), 32'd0);
    check("rst_addr", 32'(rom_addr), 32'd0);
    check("rst_sel", 32'(rom_sel), 32'd0);
    check("rst_state", 32'(anim_state), 32'd0);
    check("rst_facing", 32'(facing), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic logic [2:0] exp_sel(input logic [2:0] s);
    return MIRROR ? {s[2:1], 1'b0} : s;
  endfunction

  typedef struct {
    logic       ml, mr, air;
    logic [1:0] st;
    logic       face;
    logic [2:0] sel;
  } vec_t;

  vec_t tbl[18];

  initial begin
    for (int i = 0; i < 13; i++) begin
      tbl[i] = '{ml: 0, mr: 1, air: 0, st: (i >= 6 && i < 12) ? 2'd2 : 2'd1, face: 0,
                 sel: (i >= 6 && i < 12) ? 3'd0 : 3'd2};
    end
    tbl[13] = '{ml: 1, mr: 0, air: 1, st: 2'd3, face: 1, sel: 3'd5};
    tbl[14] = '{ml: 0, mr: 0, air: 1, st: 2'd3, face: 1, sel: 3'd5};
    tbl[15] = '{ml: 1, mr: 0, air: 0, st: 2'd1, face: 1, sel: 3'd3};
    tbl[16] = '{ml: 1, mr: 1, air: 0, st: 2'd0, face: 1, sel: 3'd1};
    tbl[17] = '{ml: 0, mr: 1, air: 0, st: 2'd1, face: 0, sel: 3'd2};

    rst_n = 1'b0; frame_tick = 1'b0;
    mario_x = '0; mario_y = '0; hcount = '0; vcount = '0;
    move_left = 1'b0; move_right = 1'b0; airborne = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_pv", 32'(pix_valid), 32'd0);
    check("reset_state", 32'(anim_state), 32'd0);
    rst_n = 1'b1;

    // Unarmed sweep over the origin, where the reset position would otherwise hit.
    for (int i = 0; i < 40; i++) begin
      hcount = 10'(i % 8);
      vcount = 10'(i / 8);
      step();
      check("unarmed_pv", 32'(pix_valid), 32'd0);
    end

    // Basic hit: position (100,50), scan (105,52).
    mario_x = 10'd100; mario_y = 10'd50; frame_tick = 1'b1; hcount = '0; vcount = '0;
    step();
    frame_tick = 1'b0; hcount = 10'd105; vcount = 10'd52;
    step();
    check("hit_addr", 32'(rom_addr), 32'd69);
    check("hit_sel", 32'(rom_sel), 32'd0);
    hcount = '0; vcount = '0;
    step();
    step();
    check("hit_pv", 32'(pix_valid), 32'd1);
    check("hit_rgb", 32'(pix_rgb), 32'h15A);

    // Colour key then opaque green on back-to-back pixels.
    hcount = 10'd103; vcount = 10'd50;
    step();
    hcount = 10'd104;
    step();
    hcount = '0; vcount = '0;
    step();
    check("key_pv", 32'(pix_valid), 32'd0);
    check("key_rgb", 32'(pix_rgb), 32'd0);
    step();
    check("green_pv", 32'(pix_valid), 32'd1);
    check("green_rgb", 32'(pix_rgb), 32'h0F0);

    // Horizontal wrap past 1023, then reset with pixels in flight.
    mario_x = 10'd1020; mario_y = 10'd0; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0; hcount = 10'd2; vcount = 10'd0;
    step();
    check("wrap_addr", 32'(rom_addr), 32'd6);
    step();
    step();
    check("wrap_pv", 32'(pix_valid), 32'd1);
    check("wrap_rgb", 32'(pix_rgb), 32'h01F);
    do_reset();
    step();
    check("post_rst_pv", 32'(pix_valid), 32'd0);

    // Animation table: one tick per row, checked once rom_sel has caught up.
    hcount = '0; vcount = 10'd600;
    for (int i = 0; i < 18; i++) begin
      move_left = tbl[i].ml; move_right = tbl[i].mr; airborne = tbl[i].air;
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      check($sformatf("tbl%0d_state", i), 32'(anim_state), 32'(tbl[i].st));
      check($sformatf("tbl%0d_facing", i), 32'(facing), 32'(tbl[i].face));
      check($sformatf("tbl%0d_sel", i), 32'(rom_sel), 32'(exp_sel(tbl[i].sel)));
    end

    // Jumping left: column 0 maps to column 31 when mirroring.
    mario_x = 10'd200; mario_y = 10'd300;
    move_left = 1'b1; move_right = 1'b0; airborne = 1'b1; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0; hcount = 10'd200; vcount = 10'd300;
    step();
    check("jump_sel", 32'(rom_sel), MIRROR ? 32'd4 : 32'd5);
    check("jump_col", 32'(rom_addr[4:0]), MIRROR ? 32'd31 : 32'd0);

    // Randomized run against the model.
    for (int n = 0; n < 4000; n++) begin
      frame_tick = ($urandom_range(0, 11) == 0);
      if (frame_tick) begin
        mario_x = 10'($urandom_range(0, 1023));
        mario_y = 10'($urandom_range(0, 1023));
        move_left = 1'($urandom_range(0, 1));
        move_right = 1'($urandom_range(0, 1));
        airborne = ($urandom_range(0, 3) == 0);
      end
      hcount = 10'((m_px + int'($urandom_range(0, 44)) + 1020) % 1024);
      vcount = 10'((m_py + int'($urandom_range(0, 44)) + 1020) % 1024);
      if ($urandom_range(0, 999) == 0) do_reset();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
